// File: rtl/rotate_xy.sv
// rotate_xy: rotates (x, y) by the angle given as a sin/cos pair (Q2.25, 27-bit signed).
// Latency: 3 cycles (input reg -> product reg -> rounded/limited output reg).
// Backpressure: global stall, in_ready = en & (~out_valid | out_ready); bubbles are not compressed.
//
// Ports:
//   clk, rst        rising-edge clock; synchronous reset, active-low (rst = 0 resets)
//   en              clock enable; 0 freezes every register (reset still wins)
//   in_valid/ready  input handshake for x_in, y_in, sin, cos
//   out_valid/ready output handshake for x_out, y_out
//   x_out, y_out    x' = x*cos - y*sin, y' = x*sin + y*cos, rounded half-up to Q2.25
//
// Build option: define ROTATE_XY_SAT_EN to clamp out-of-range results to
// 0x3FFFFFF / 0x4000000; without it results wrap to the low 27 bits.

module rotate_xy (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [26:0] x_in,
  input  logic signed [26:0] y_in,
  input  logic signed [26:0] sin,
  input  logic signed [26:0] cos,
  output logic               out_valid,
  input  logic               out_ready,
  output logic        [26:0] x_out,
  output logic        [26:0] y_out
);

  // One advance signal for the whole pipe: every stage moves together or holds.
  logic adv;
  assign adv      = en & (~out_valid | out_ready);
  assign in_ready = adv;

  // Stage valids; v3 drives out_valid directly.
  logic v1, v2, v3;
  assign out_valid = v3;

  // S1: registered operands.
  logic signed [26:0] x1, y1, s1, c1;

  // S2: full-precision 54-bit products.
  logic signed [53:0] p_xc, p_ys, p_xs, p_yc;

  // S3 combinational: 55-bit sums with the half-LSB (2^24) already added.
  logic signed [54:0] sum_x, sum_y;
  assign sum_x = $signed({p_xc[53], p_xc}) - $signed({p_ys[53], p_ys}) + 55'sh1000000;
  assign sum_y = $signed({p_xs[53], p_xs}) + $signed({p_yc[53], p_yc}) + 55'sh1000000;

  // Arithmetic shift right by 25 is just the upper slice; floor after adding
  // half an LSB gives round-half-up toward +inf.
  logic signed [29:0] q_x, q_y;
  assign q_x = sum_x[54:25];
  assign q_y = sum_y[54:25];

  logic [26:0] lim_x, lim_y;
  logic        unused_bits;

`ifdef ROTATE_XY_SAT_EN
  // A value fits in 27 bits only when bits [29:26] are all copies of the sign.
  logic ovf_x, ovf_y;
  assign ovf_x = ~((&q_x[29:26]) | ~(|q_x[29:26]));
  assign ovf_y = ~((&q_y[29:26]) | ~(|q_y[29:26]));

  always_comb begin
    lim_x = q_x[26:0];
    lim_y = q_y[26:0];
    if (ovf_x) lim_x = q_x[29] ? 27'h4000000 : 27'h3FFFFFF;
    if (ovf_y) lim_y = q_y[29] ? 27'h4000000 : 27'h3FFFFFF;
  end

  // Fraction bits below the LSB are consumed only by the rounding add.
  assign unused_bits = ^{sum_x[24:0], sum_y[24:0]};
`else
  // Plain two's-complement wrap to 27 bits.
  always_comb begin
    lim_x = q_x[26:0];
    lim_y = q_y[26:0];
  end

  assign unused_bits = ^{sum_x[24:0], sum_y[24:0], q_x[29:27], q_y[29:27]};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      x1    <= '0;
      y1    <= '0;
      s1    <= '0;
      c1    <= '0;
      p_xc  <= '0;
      p_ys  <= '0;
      p_xs  <= '0;
      p_yc  <= '0;
      x_out <= '0;
      y_out <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      // Data registers only load behind a valid; bubbles leave them untouched.
      if (in_valid) begin
        x1 <= x_in;
        y1 <= y_in;
        s1 <= sin;
        c1 <= cos;
      end
      if (v1) begin
        p_xc <= x1 * c1;
        p_ys <= y1 * s1;
        p_xs <= x1 * s1;
        p_yc <= y1 * c1;
      end
      if (v2) begin
        x_out <= lim_x;
        y_out <= lim_y;
      end
    end
  end

endmodule

// File: tb/tb_rotate_xy.sv
// tb_rotate_xy: self-checking bench for rotate_xy.
// Latency: checks out_valid appears on the third edge counted from the accepting edge.
// Backpressure: streams with out_ready stalls and en gaps against a scoreboard of expected results.

module tb_rotate_xy;

  logic        clk;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] x_in, y_in, sin, cos;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] x_out, y_out;

  int tests = 0;
  int fails = 0;

  localparam logic [26:0] ONE  = 27'h2000000;
  localparam logic [26:0] HALF = 27'h1000000;

  rotate_xy dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .sin       (sin),
    .cos       (cos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [26:0] x, y, s, c;
    logic [26:0] ex, ey;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] neg27(input logic [26:0] v);
    return ~v + 27'd1;
  endfunction

  // Distinct small operands for stream tests; rotated by 90 degrees these give (-y, x).
  function automatic logic [26:0] sx(input int i);
    return 27'(32'h100 + 32'(i) * 32'h11);
  endfunction

  function automatic logic [26:0] sy(input int i);
    return 27'(32'h2000 + 32'(i) * 32'h235);
  endfunction

  task automatic drain_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    in_valid = 1'b0;
    repeat (cycles) begin
      if (out_valid) seen++;
      tick();
    end
    chk(tag, seen, 0);
  endtask

  // Streams n vectors; out_ready is low for loop cycles st_lo..st_hi and en
  // is low for cycles en_lo..en_hi. Results are checked in order.
  task automatic run_stream(input string tag, input int n, input int base,
                            input int st_lo, input int st_hi,
                            input int en_lo, input int en_hi);
    int          sent, got, k;
    logic        hold, pv, exp_rdy;
    logic [26:0] px, py;
    sent = 0; got = 0; k = 0;
    hold = 1'b0; pv = 1'b0; px = '0; py = '0;
    while (got < n && k < 200) begin
      out_ready = !(k >= st_lo && k <= st_hi);
      en        = !(k >= en_lo && k <= en_hi);
      in_valid  = (sent < n);
      x_in      = sx(base + sent);
      y_in      = sy(base + sent);
      sin       = ONE;
      cos       = '0;
      #1;
      if (hold) begin
        chk({tag, "_hold_valid"}, out_valid, pv);
        chk({tag, "_hold_x"}, x_out, px);
        chk({tag, "_hold_y"}, y_out, py);
      end
      exp_rdy = en && (!out_valid || out_ready);
      chk({tag, "_in_ready"}, in_ready, exp_rdy);
      if (en && out_valid && out_ready) begin
        chk({tag, "_x"}, x_out, neg27(sy(base + got)));
        chk({tag, "_y"}, y_out, sx(base + got));
        got++;
      end
      hold = !exp_rdy;
      pv = out_valid; px = x_out; py = y_out;
      if (in_valid && in_ready) sent++;
      tick();
      k++;
    end
    chk({tag, "_count"}, got, n);
    in_valid  = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
  endtask

  logic [26:0] ovf_ey, big_ex, neg_ey;

  initial begin
`ifdef ROTATE_XY_SAT_EN
    ovf_ey = 27'h3FFFFFF;
    big_ex = 27'h3FFFFFF;
    neg_ey = 27'h4000000;
`else
    ovf_ey = 27'h7FFFFFE;
    big_ex = 27'h0000000;
    neg_ey = 27'h0000000;
`endif
    //          name        x            y            sin          cos          ex           ey
    tbl[0] = '{"identity", 27'h0100000, 27'h7FFFFFF, 27'h0000000, ONE,         27'h0100000, 27'h7FFFFFF};
    tbl[1] = '{"rot90",    27'h0000123, 27'h0000456, ONE,         27'h0000000, 27'h7FFFBAA, 27'h0000123};
    tbl[2] = '{"rnd_p05",  27'h0000001, 27'h0000000, 27'h0000000, HALF,        27'h0000001, 27'h0000000};
    tbl[3] = '{"rnd_m05",  27'h7FFFFFF, 27'h0000000, 27'h0000000, HALF,        27'h0000000, 27'h0000000};
    tbl[4] = '{"rnd_p15",  27'h0000003, 27'h0000000, 27'h0000000, HALF,        27'h0000002, 27'h0000000};
    tbl[5] = '{"rnd_m15",  27'h7FFFFFD, 27'h0000000, 27'h0000000, HALF,        27'h7FFFFFF, 27'h0000000};
    tbl[6] = '{"mixed",    27'h2000000, 27'h1000000, HALF,        HALF,        27'h0800000, 27'h1800000};
    tbl[7] = '{"ovf_pos",  27'h3FFFFFF, 27'h3FFFFFF, ONE,         ONE,         27'h0000000, ovf_ey};
    tbl[8] = '{"ovf_big",  27'h4000000, 27'h0000000, ONE,         27'h4000000, big_ex,      27'h4000000};

    // Reset with en low: reset must still take effect.
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; sin = '0; cos = '0;
    tick(); tick();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_x_out", x_out, 27'h0);
    chk("reset_y_out", y_out, 27'h0);
    chk("reset_in_ready_en0", in_ready, 1'b0);
    en = 1'b1;
    #1;
    chk("reset_in_ready_en1", in_ready, 1'b1);
    rst = 1'b1; out_ready = 1'b1;
    tick();

    // Single vectors through an empty pipe: latency and arithmetic.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      x_in = tbl[i].x; y_in = tbl[i].y; sin = tbl[i].s; cos = tbl[i].c;
      #1;
      chk({tbl[i].name, "_in_ready"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk({tbl[i].name, "_lat1"}, out_valid, 1'b0);
      tick();
      chk({tbl[i].name, "_lat2"}, out_valid, 1'b0);
      tick();
      chk({tbl[i].name, "_lat3"}, out_valid, 1'b1);
      chk({tbl[i].name, "_x"}, x_out, tbl[i].ex);
      chk({tbl[i].name, "_y"}, y_out, tbl[i].ey);
      tick();
      chk({tbl[i].name, "_consumed"}, out_valid, 1'b0);
    end

    // Negative overflow in y: -2 - 2 = -4.0 does not fit Q2.25.
    in_valid = 1'b1;
    x_in = 27'h4000000; y_in = 27'h4000000; sin = ONE; cos = ONE;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("ovf_neg_valid", out_valid, 1'b1);
    chk("ovf_neg_x", x_out, 27'h0);
    chk("ovf_neg_y", y_out, neg_ey);
    tick();

    // Backpressure: continuous input, out_ready low for cycles 4..8.
    run_stream("bp", 10, 0, 4, 8, -1, -2);
    drain_quiet("bp_no_extra", 6);

    // Enable gap of 4 cycles mid-stream.
    run_stream("en", 8, 20, -1, -2, 3, 6);
    drain_quiet("en_no_extra", 6);

    // Reset with three vectors in flight (held by out_ready = 0).
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x_in = sx(50 + i); y_in = sy(50 + i); sin = ONE; cos = '0;
      tick();
    end
    in_valid = 1'b0;
    chk("rst_pre_full", out_valid, 1'b1);
    rst = 1'b0; en = 1'b0;
    tick();
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_x", x_out, 27'h0);
    chk("rst_mid_y", y_out, 27'h0);
    rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    drain_quiet("rst_no_stale", 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
